batalha_desafio: RTL

- Sequential challenger for the battle game, acting as player A's side.
- Generates pseudo-random valid 3-bit codes: not 000, not 111.
- Presents each code to player B and waits for B's confirmed answer.
- Scores the answer: B wins a round when it enters the bitwise complement of the code.
- Runs a fixed number of rounds per game; sits between the board's debounced switch/button inputs and the score display.

---
 rtl/batalha_pkg.sv | 37 +++
 rtl/batalha_lfsr.sv | 34 +++
 rtl/batalha_desafio.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/batalha_pkg.sv
// ----------------------------------------------------------------------------
// batalha_pkg
// Shared definitions for the battle-game challenger (player A side):
//   - estado_t        : challenger state machine states
//   - LFSR_W/LFSR_TAPS: width and feedback taps of the code generator
//   - codigo_valido() : a 3-bit code is playable unless all bits are equal
//   - complemento()   : the answer that wins a round for player B
//   - lfsr_feedback() : Fibonacci feedback bit for the tap set
// ----------------------------------------------------------------------------
package batalha_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GERA,
        MOSTRA,
        AVALIA,
        FIM
    } estado_t;

    localparam int unsigned LFSR_W = 8;

    // Taps at bits 7, 5, 4 and 3
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic codigo_valido(input logic [2:0] codigo);
        return !((codigo == 3'b000) || (codigo == 3'b111));
    endfunction

    function automatic logic [2:0] complemento(input logic [2:0] codigo);
        return ~codigo;
    endfunction

    function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] estado);
        return ^(estado & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/batalha_lfsr.sv
// ----------------------------------------------------------------------------
// batalha_lfsr
// 8-bit Fibonacci LFSR used as the challenge code source. Shifts left and
// inserts the tap parity at bit 0 whenever 'passo' is high. Only rst_n
// reloads SEED, so the sequence carries over from one game to the next.
//
// Parameters:
//   SEED    reset value, must be nonzero
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   passo   in   step enable
//   estado  out  current LFSR contents
// ----------------------------------------------------------------------------
module batalha_lfsr
    import batalha_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'h01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              passo,
    output logic [LFSR_W-1:0] estado
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= SEED;
        end else if (passo) begin
            estado <= {estado[LFSR_W-2:0], lfsr_feedback(estado)};
        end
    end

endmodule

// File: rtl/batalha_desafio.sv
// ----------------------------------------------------------------------------
// batalha_desafio
// Sequential challenger for the battle game (player A). Draws valid 3-bit
// codes (never 000 or 111) from an LFSR, presents each one to player B,
// scores B's confirmed answer (win = bitwise complement of the code) and
// runs ROUNDS rounds per game.
//
// Optional feature macro: BATALHA_TIMEOUT_EN
//   defined   : a per-round answer timer is built; after TIMEOUT cycles in
//               MOSTRA without jb_valid the round is scored as a miss.
//   undefined : no timer; MOSTRA waits indefinitely, TIMEOUT unused.
//
// Parameters:
//   ROUNDS   rounds per game, 1..15
//   TIMEOUT  answer window in cycles, 1..65535
//   SEED     LFSR reset value, nonzero
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin a game (honoured in IDLE or FIM only)
//   jb[2:0]   in   player B answer
//   jb_valid  in   one-cycle answer confirm strobe
//   ja[2:0]   out  current challenge
//   ja_valid  out  challenge presented, answer awaited
//   acerto    out  one-cycle pulse, round won by B
//   erro      out  one-cycle pulse, round lost (wrong answer / timeout)
//   pontos    out  B score in the current game
//   ocupado   out  game in progress
//   fim       out  game finished, held until the next start
// ----------------------------------------------------------------------------
module batalha_desafio
    import batalha_pkg::*;
#(
    parameter int unsigned       ROUNDS  = 8,
    parameter int unsigned       TIMEOUT = 255,
    parameter logic [LFSR_W-1:0] SEED    = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] jb,
    input  logic       jb_valid,
    output logic [2:0] ja,
    output logic       ja_valid,
    output logic       acerto,
    output logic       erro,
    output logic [3:0] pontos,
    output logic       ocupado,
    output logic       fim
);

    localparam logic [3:0] ROUNDS_4 = 4'(ROUNDS);

    // Elaboration-time parameter range checks
    if (ROUNDS < 1 || ROUNDS > 15) begin : g_chk_rounds
        $error("batalha_desafio: ROUNDS out of range 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_chk_timeout
        $error("batalha_desafio: TIMEOUT out of range 1..65535");
    end
    if (SEED == '0) begin : g_chk_seed
        $error("batalha_desafio: SEED must be nonzero");
    end

    estado_t           estado;
    logic [LFSR_W-1:0] lfsr_q;
    logic [3:0]        rodada;
    logic              expira;

    batalha_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .passo  (estado == GERA),
        .estado (lfsr_q)
    );

`ifdef BATALHA_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    logic [15:0] timer;

    // Held at zero outside MOSTRA so it is clear on entry; expiry is the
    // TIMEOUT-th MOSTRA cycle without an answer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (estado != MOSTRA) begin
            timer <= '0;
        end else if (!jb_valid) begin
            timer <= timer + 16'd1;
        end
    end

    assign expira = (estado == MOSTRA) && !jb_valid && (timer == TIMEOUT_M1);
`else
    assign expira = 1'b0;
`endif

    // Scoring is resolved on the edge that leaves MOSTRA, so acerto/erro and
    // the updated pontos are visible for exactly the AVALIA cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= IDLE;
            ja       <= '0;
            ja_valid <= 1'b0;
            acerto   <= 1'b0;
            erro     <= 1'b0;
            pontos   <= '0;
            rodada   <= '0;
            ocupado  <= 1'b0;
            fim      <= 1'b0;
        end else begin
            acerto <= 1'b0;
            erro   <= 1'b0;

            case (estado)
                IDLE, FIM: begin
                    if (start) begin
                        estado  <= GERA;
                        pontos  <= '0;
                        rodada  <= '0;
                        ocupado <= 1'b1;
                        fim     <= 1'b0;
                    end
                end

                GERA: begin
                    if (codigo_valido(lfsr_q[2:0])) begin
                        ja       <= lfsr_q[2:0];
                        ja_valid <= 1'b1;
                        estado   <= MOSTRA;
                    end
                end

                MOSTRA: begin
                    if (jb_valid) begin
                        ja_valid <= 1'b0;
                        rodada   <= rodada + 4'd1;
                        estado   <= AVALIA;
                        if (jb == complemento(ja)) begin
                            acerto <= 1'b1;
                            pontos <= pontos + 4'd1;
                        end else begin
                            erro <= 1'b1;
                        end
                    end else if (expira) begin
                        ja_valid <= 1'b0;
                        rodada   <= rodada + 4'd1;
                        estado   <= AVALIA;
                        erro     <= 1'b1;
                    end
                end

                AVALIA: begin
                    if (rodada == ROUNDS_4) begin
                        estado  <= FIM;
                        ocupado <= 1'b0;
                        fim     <= 1'b1;
                    end else begin
                        estado <= GERA;
                    end
                end

                default: begin
                    estado   <= IDLE;
                    ja_valid <= 1'b0;
                    ocupado  <= 1'b0;
                    fim      <= 1'b0;
                end
            endcase
        end
    end

endmodule
